xbar_ctrl_writer: RTL and testbench

- Produces the 42-bit control word consumed by the blocking crossbar, which selects one input port via muxsel and one output port via decsel.
- Accepts route configuration commands over a val/rdy stream, drives and holds the control word, and gates the crossbar with an enable.
- Counts completed transfers on the routed path, then returns a completion response over a second val/rdy stream.
- Sits between the packet-routing scheduler (upstream) and the crossbar's control input.

---
 rtl/xbar_ctrl_writer.sv | 119 +++++++++++
 tb/tb_xbar_ctrl_writer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_ctrl_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : xbar_ctrl_writer
// Purpose  : Builds and holds the control word of a blocking crossbar. It
//            accepts a route command {in_sel, out_sel, count}, programs the
//            mux/decoder selects, enables the crossbar and counts completed
//            transfers until count is reached or the route is aborted. It then
//            returns the number of completed transfers as a response.
// Ports    : clk, reset (async, active-low)
//            recv_msg/recv_val/recv_rdy : route command stream (in)
//            send_msg/send_val/send_rdy : completion response stream (out)
//            abort                      : end the active route early
//            xfer_val/xfer_rdy          : handshake of the routed output port
//            control                    : crossbar control word
//            xbar_en                    : crossbar enable
// Revision : 1.0 - initial release
// ============================================================================
module xbar_ctrl_writer #(
  parameter int N_INPUTS  = 2,
  parameter int N_OUTPUTS = 2,
  parameter int CNT_W     = 8,
  parameter int CTRL_W    = 42,
  localparam int SEL_I    = (N_INPUTS  > 2) ? $clog2(N_INPUTS)  : 1,
  localparam int SEL_O    = (N_OUTPUTS > 2) ? $clog2(N_OUTPUTS) : 1,
  localparam int MSG_W    = SEL_I + SEL_O + CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MSG_W-1:0]  recv_msg,
  input  logic              recv_val,
  output logic              recv_rdy,
  output logic [CNT_W-1:0]  send_msg,
  output logic              send_val,
  input  logic              send_rdy,
  input  logic              abort,
  input  logic              xfer_val,
  input  logic              xfer_rdy,
  output logic [CTRL_W-1:0] control,
  output logic              xbar_en
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   done_cnt;
  logic [SEL_I-1:0]   cmd_in_sel;
  logic [SEL_O-1:0]   cmd_out_sel;
  logic [CNT_W-1:0]   cmd_count;
  logic [CTRL_W-1:0]  ctrl_new;
  logic               accept;
  logic               xfer;
  logic               last_xfer;

  assign cmd_in_sel  = recv_msg[MSG_W-1 -: SEL_I];
  assign cmd_out_sel = recv_msg[SEL_O+CNT_W-1 -: SEL_O];
  assign cmd_count   = recv_msg[CNT_W-1:0];

  // recv_rdy is a pure decode of state, gated low while reset is asserted.
  assign recv_rdy  = (state == IDLE) & reset;
  assign accept    = recv_val & recv_rdy;

  // xbar_en is only ever high in ACTIVE, so it doubles as the transfer qualifier.
  assign xfer      = xbar_en & xfer_val & xfer_rdy;
  assign last_xfer = xfer & ((done_cnt + CNT_W'(1)) == count_q);

  // The counter register itself is the response payload; it is frozen in RESP.
  assign send_msg  = done_cnt;

  always_comb begin
    ctrl_new = '0;
    ctrl_new[CTRL_W-1 -: SEL_I]       = cmd_in_sel;
    ctrl_new[CTRL_W-1-SEL_I -: SEL_O] = cmd_out_sel;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = (count_q == '0) ? RESP : ACTIVE;
      ACTIVE:  if (abort || last_xfer) state_nxt = RESP;
      RESP:    if (send_val && send_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      control  <= '0;
      xbar_en  <= 1'b0;
      send_val <= 1'b0;
      count_q  <= '0;
      done_cnt <= '0;
    end else begin
      state    <= state_nxt;
      // Enable and response valid are registered copies of the next state so
      // they change on exactly the edge that enters/leaves ACTIVE and RESP.
      xbar_en  <= (state_nxt == ACTIVE);
      send_val <= (state_nxt == RESP);
      if (accept) begin
        control  <= ctrl_new;
        count_q  <= cmd_count;
        done_cnt <= '0;
      end else if (xfer) begin
        done_cnt <= done_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xbar_ctrl_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_xbar_ctrl_writer
// Purpose  : Self-checking bench for xbar_ctrl_writer. Each command's
//            expected enable window and response are computed at transaction
//            level from the per-cycle stimulus vectors before driving them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xbar_ctrl_writer;

  localparam int CNT_W  = 8;
  localparam int CTRL_W = 42;
  localparam int MSG_W  = 1 + 1 + CNT_W;
  localparam int MAXC   = 128;

  logic              clk;
  logic              reset;
  logic [MSG_W-1:0]  recv_msg;
  logic              recv_val;
  logic              recv_rdy;
  logic [CNT_W-1:0]  send_msg;
  logic              send_val;
  logic              send_rdy;
  logic              abort;
  logic              xfer_val;
  logic              xfer_rdy;
  logic [CTRL_W-1:0] control;
  logic              xbar_en;

  int checks = 0;
  int errors = 0;

  xbar_ctrl_writer #(
    .N_INPUTS (2),
    .N_OUTPUTS(2),
    .CNT_W    (CNT_W),
    .CTRL_W   (CTRL_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .recv_msg(recv_msg),
    .recv_val(recv_val),
    .recv_rdy(recv_rdy),
    .send_msg(send_msg),
    .send_val(send_val),
    .send_rdy(send_rdy),
    .abort   (abort),
    .xfer_val(xfer_val),
    .xfer_rdy(xfer_rdy),
    .control (control),
    .xbar_en (xbar_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CTRL_W-1:0] exp_ctrl(input logic in_sel, input logic out_sel);
    logic [CTRL_W-1:0] c;
    c = '0;
    c[CTRL_W-1] = in_sel;
    c[CTRL_W-2] = out_sel;
    return c;
  endfunction

  // mode 0: back-to-back handshakes; 1: xfer_rdy toggling 0/1;
  // 2: abort together with transfer number abort_n; 3: random.
  task automatic run_cmd(input logic in_sel, input logic out_sel, input int cnt,
                         input int mode, input int abort_n, input int resp_delay);
    logic [MAXC-1:0] v, r, a;
    int done, stop;
    logic [CTRL_W-1:0] ec;
    ec = exp_ctrl(in_sel, out_sel);
    for (int i = 0; i < MAXC; i++) begin
      case (mode)
        0: begin v[i] = 1'b1; r[i] = 1'b1; a[i] = 1'b0; end
        1: begin v[i] = 1'b1; r[i] = i[0]; a[i] = 1'b0; end
        2: begin v[i] = 1'b1; r[i] = 1'b1; a[i] = (i == abort_n - 1); end
        default: begin
          v[i] = ($urandom_range(0, 3) != 0);
          r[i] = ($urandom_range(0, 3) != 0);
          a[i] = ($urandom_range(0, 24) == 0);
        end
      endcase
    end
    a[MAXC-1] = 1'b1;

    // Reference: walk the active-cycle stimulus, counting handshakes until
    // the count is reached or an abort is seen.
    done = 0;
    stop = -1;
    if (cnt != 0) begin
      for (int i = 0; i < MAXC; i++) begin
        if (v[i] && r[i]) done++;
        if (done == cnt || a[i]) begin
          stop = i;
          break;
        end
      end
    end

    check("idle_rdy", recv_rdy, 1'b1);
    recv_msg = {in_sel, out_sel, cnt[CNT_W-1:0]};
    recv_val = 1'b1;
    tick();                                   // acceptance edge
    recv_val = 1'b0;
    recv_msg = '0;
    check("load_rdy", recv_rdy, 1'b0);
    check("load_en", xbar_en, 1'b0);
    check("ctrl", control, ec);
    // Handshakes and abort during LOAD must be ignored.
    xfer_val = $urandom_range(0, 1);
    xfer_rdy = $urandom_range(0, 1);
    abort    = $urandom_range(0, 1);
    tick();
    for (int i = 0; i <= stop; i++) begin
      check("act_en", xbar_en, 1'b1);
      check("act_sval", send_val, 1'b0);
      check("act_rdy", recv_rdy, 1'b0);
      xfer_val = v[i];
      xfer_rdy = r[i];
      abort    = a[i];
      tick();
    end
    xfer_val = 1'b0;
    xfer_rdy = 1'b0;
    abort    = 1'b0;
    check("resp_en", xbar_en, 1'b0);
    check("resp_val", send_val, 1'b1);
    check("resp_msg", send_msg, done[CNT_W-1:0]);
    for (int d = 0; d < resp_delay; d++) begin
      abort    = $urandom_range(0, 1);
      xfer_val = 1'b1;
      xfer_rdy = 1'b1;
      tick();
      check("hold_val", send_val, 1'b1);
      check("hold_msg", send_msg, done[CNT_W-1:0]);
      check("hold_rdy", recv_rdy, 1'b0);
      check("hold_en", xbar_en, 1'b0);
    end
    abort    = 1'b0;
    xfer_val = 1'b0;
    xfer_rdy = 1'b0;
    send_rdy = 1'b1;
    tick();
    send_rdy = 1'b0;
    check("post_val", send_val, 1'b0);
    check("post_rdy", recv_rdy, 1'b1);
    check("post_ctrl", control, ec);
  endtask

  initial begin
    reset    = 1'b0;
    recv_msg = '0;
    recv_val = 1'b0;
    send_rdy = 1'b0;
    abort    = 1'b0;
    xfer_val = 1'b0;
    xfer_rdy = 1'b0;

    // Reset sequence: 3 cycles low.
    repeat (3) tick();
    check("rst_rdy", recv_rdy, 1'b0);
    check("rst_ctrl", control, '0);
    check("rst_en", xbar_en, 1'b0);
    check("rst_sval", send_val, 1'b0);
    check("rst_smsg", send_msg, '0);
    reset = 1'b1;
    tick();
    check("rel_rdy", recv_rdy, 1'b1);

    // Directed cases.
    run_cmd(1'b1, 1'b0, 3, 0, 0, 0);     // basic route
    run_cmd(1'b0, 1'b0, 2, 1, 0, 4);     // backpressure
    run_cmd(1'b0, 1'b1, 0, 0, 0, 1);     // zero count
    run_cmd(1'b1, 1'b1, 10, 2, 4, 0);    // abort with 4th transfer
    // Abort while idle has no effect.
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    check("idle_abort_rdy", recv_rdy, 1'b1);
    check("idle_abort_val", send_val, 1'b0);
    run_cmd(1'b1, 1'b0, 1, 0, 0, 0);

    // Async reset while ACTIVE with done_cnt=2.
    recv_msg = {1'b1, 1'b1, 8'd10};
    recv_val = 1'b1;
    tick();
    recv_val = 1'b0;
    tick();                               // LOAD -> ACTIVE
    xfer_val = 1'b1;
    xfer_rdy = 1'b1;
    tick();
    tick();                               // two transfers counted
    xfer_val = 1'b0;
    xfer_rdy = 1'b0;
    check("pre_rst_en", xbar_en, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst_ctrl", control, '0);
    check("arst_en", xbar_en, 1'b0);
    check("arst_val", send_val, 1'b0);
    check("arst_rdy", recv_rdy, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("arst_noresp", send_val, 1'b0);
    check("arst_idle", recv_rdy, 1'b1);
    run_cmd(1'b0, 1'b1, 2, 0, 0, 0);

    // Randomized commands.
    for (int k = 0; k < 40; k++) begin
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 20), 3, 0, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
